// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer write arbiter.
package fb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_BUFFER_WIDTH      = 160;
  localparam int DEF_BUFFER_HEIGHT     = 120;
  localparam int DEF_BUFFER_DATA_WIDTH = 12;

  localparam int REQ_BG      = 0;
  localparam int REQ_SPRITE  = 1;
  localparam int REQ_OVERLAY = 2;

  // Requester index reached by stepping 'offset' positions past 'base', wrapping at n.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester with valid set, starting
// one position after the previous owner.
module rr_picker
  import fb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      next_grant,
  output logic               any_req
);

  logic found;
  int   idx;

  always_comb begin
    next_grant = '0;
    found      = 1'b0;
    idx        = 0;
    any_req    = |req;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = rr_index(int'(last_grant), k, NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        next_grant = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: round-robin burst grants, one registered write port.
// Optional macro FB_ARB_BOUNDS_CHECK_EN drops out-of-range writes and flags addr_error.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int NUM_REQ           = 3,
  parameter int BUFFER_WIDTH      = DEF_BUFFER_WIDTH,
  parameter int BUFFER_HEIGHT     = DEF_BUFFER_HEIGHT,
  parameter int BUFFER_DATA_WIDTH = DEF_BUFFER_DATA_WIDTH,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
  parameter int MAX_BURST         = 64,
  localparam int GW               = $clog2(NUM_REQ)
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0]                     req_last,
  input  logic [NUM_REQ*BUFFER_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*BUFFER_DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic                                   write_en,
  output logic [BUFFER_ADDR_WIDTH-1:0]           write_addr,
  output logic [BUFFER_DATA_WIDTH-1:0]           write_data,
  output logic [GW-1:0]                          grant_id,
  output logic                                   busy
`ifdef FB_ARB_BOUNDS_CHECK_EN
  ,
  output logic                                   addr_error
`endif
);

  localparam int AW    = BUFFER_ADDR_WIDTH;
  localparam int DW    = BUFFER_DATA_WIDTH;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

  arb_state_t       state, state_nxt;
  logic [GW-1:0]    last_grant, last_grant_nxt;
  logic [GW-1:0]    grant_id_nxt;
  logic [GW-1:0]    pick;
  logic             any_req;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  logic [AW-1:0] addr_arr [NUM_REQ];
  logic [DW-1:0] data_arr [NUM_REQ];

  logic          vld_p0;
  logic          last_p0;
  logic          limit_p0;
  logic          wr_ok_p0;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] data_p0;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*AW +: AW];
    assign data_arr[i] = req_data[i*DW +: DW];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .next_grant (pick),
    .any_req    (any_req)
  );

  // Stage p0: beat handshake against the current owner only.
  assign req_ready = (state == BURST) ? (NUM_REQ'(1) << grant_id) : '0;
  assign busy      = (state == BURST);
  assign vld_p0    = (state == BURST) && req_valid[grant_id];
  assign last_p0   = req_last[grant_id];
  assign addr_p0   = addr_arr[grant_id];
  assign data_p0   = data_arr[grant_id];
  assign limit_p0  = (MAX_BURST > 0) && (beat_cnt == CNT_LAST);

`ifdef FB_ARB_BOUNDS_CHECK_EN
  localparam logic [AW:0] FB_SIZE = (AW+1)'(BUFFER_WIDTH * BUFFER_HEIGHT);
  logic in_range_p0;
  assign in_range_p0 = ({1'b0, addr_p0} < FB_SIZE);
  assign wr_ok_p0    = vld_p0 && in_range_p0;
`else
  assign wr_ok_p0    = vld_p0;
`endif

  always_comb begin
    state_nxt      = state;
    grant_id_nxt   = grant_id;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      ARB: begin
        if (any_req) begin
          grant_id_nxt = pick;
          beat_cnt_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        if (vld_p0) begin
          // A forced release behaves like a normal last beat: the owner requeues.
          if (last_p0 || limit_p0) begin
            state_nxt      = ARB;
            last_grant_nxt = grant_id;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ARB;
      last_grant <= GW'(NUM_REQ - 1);
      grant_id   <= '0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant_id   <= grant_id_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Stage p1: registered framebuffer write port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      write_en <= wr_ok_p0;
      if (wr_ok_p0) begin
        write_addr <= addr_p0;
        write_data <= data_p0;
      end
    end
  end

`ifdef FB_ARB_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_error <= 1'b0;
    end else if (vld_p0 && !in_range_p0) begin
      addr_error <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a cycle-level reference model.
module tb_fb_write_arbiter;
  import fb_pkg::*;

  localparam int NR      = 3;
  localparam int AW      = 15;
  localparam int DW      = 12;
  localparam int MAXB    = 64;
  localparam int FB_SIZE = 160 * 120;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_last = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              write_en;
  logic [AW-1:0]     write_addr;
  logic [DW-1:0]     write_data;
  logic [1:0]        grant_id;
  logic              busy;
`ifdef FB_ARB_BOUNDS_CHECK_EN
  logic              addr_error;
`endif

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .NUM_REQ(NR), .BUFFER_WIDTH(160), .BUFFER_HEIGHT(120),
    .BUFFER_DATA_WIDTH(DW), .BUFFER_ADDR_WIDTH(AW), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .grant_id(grant_id), .busy(busy)
`ifdef FB_ARB_BOUNDS_CHECK_EN
    , .addr_error(addr_error)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- requester sources ----------------
  int s_len[NR], s_left[NR], s_beat[NR], s_addr[NR], s_data[NR];
  bit s_hold[NR];
  logic [NR-1:0] hs_q = '0;

  always @(posedge clk) hs_q <= req_valid & req_ready;

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      bit v;
      v = !s_hold[i] && (s_left[i] > 0);
      req_valid[i] = v;
      // Idle requesters present junk last/addr that must be ignored.
      req_last[i]  = v ? (s_len[i] > 0 && s_beat[i] == s_len[i] - 1) : 1'b1;
      req_addr[i*AW +: AW] = v ? AW'(s_addr[i]) : AW'($urandom);
      req_data[i*DW +: DW] = DW'(s_data[i]);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs_q[i]) begin
        s_left[i]--;
        s_addr[i]++;
        s_data[i]++;
        s_beat[i] = (s_len[i] > 0 && s_beat[i] == s_len[i] - 1) ? 0 : s_beat[i] + 1;
      end
    end
    apply();
  endtask

  task automatic src(input int i, input int len, input int total, input int addr, input int data);
    s_len[i] = len; s_left[i] = total; s_beat[i] = 0;
    s_addr[i] = addr; s_data[i] = data; s_hold[i] = 1'b0;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NR; i++) src(i, 0, 0, 0, 0);
    apply();
  endtask

  // ---------------- reference model ----------------
  bit m_burst = 0;
  int m_owner = 0, m_last = NR - 1, m_beats = 0;
  bit m_we = 0;
  int m_addr = 0, m_data = 0;
  bit m_err = 0;

  function automatic int rr_first(input int last, input logic [NR-1:0] vec);
    for (int k = 1; k <= NR; k++) if (vec[(last + k) % NR]) return (last + k) % NR;
    return 0;
  endfunction

  function automatic int own_addr(input int o);
    return int'(req_addr[o*AW +: AW]);
  endfunction

  function automatic int own_data(input int o);
    return int'(req_data[o*DW +: DW]);
  endfunction

  function automatic bit out_of_range(input int a);
`ifdef FB_ARB_BOUNDS_CHECK_EN
    return a >= FB_SIZE;
`else
    return (a < 0);
`endif
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_burst <= 0; m_owner <= 0; m_last <= NR - 1; m_beats <= 0;
      m_we <= 0; m_addr <= 0; m_data <= 0; m_err <= 0;
    end else begin
      m_we <= 0;
      if (!m_burst) begin
        if (req_valid != '0) begin
          m_owner <= rr_first(m_last, req_valid);
          m_burst <= 1;
          m_beats <= 0;
        end
      end else if (req_valid[m_owner]) begin
        if (out_of_range(own_addr(m_owner))) m_err <= 1;
        else begin
          m_we <= 1; m_addr <= own_addr(m_owner); m_data <= own_data(m_owner);
        end
        if (req_last[m_owner] || (MAXB > 0 && m_beats + 1 == MAXB)) begin
          m_burst <= 0; m_last <= m_owner;
        end else m_beats <= m_beats + 1;
      end
    end
  end

  // ---------------- compare process and observation logs ----------------
  int cyc = 0;
  int wlog_addr[$];
  int wlog_data[$];
  int wlog_cyc[$];
  int glog[$];
  int first_rdy0 = -1;
  bit busy_q = 0;

  always @(negedge clk) begin
    cyc++;
    chk("ready", 32'(req_ready), m_burst ? (32'd1 << m_owner) : 32'd0);
    chk("busy", 32'(busy), 32'(m_burst));
    chk("grant_id", 32'(grant_id), 32'(m_owner));
    chk("write_en", 32'(write_en), 32'(m_we));
    chk("write_addr", 32'(write_addr), 32'(m_addr));
    chk("write_data", 32'(write_data), 32'(m_data));
`ifdef FB_ARB_BOUNDS_CHECK_EN
    chk("addr_error", 32'(addr_error), 32'(m_err));
`endif
    if (write_en === 1'b1) begin
      wlog_addr.push_back(int'(write_addr));
      wlog_data.push_back(int'(write_data));
      wlog_cyc.push_back(cyc);
    end
    if (busy === 1'b1 && !busy_q) glog.push_back(int'(grant_id));
    busy_q = (busy === 1'b1);
    if (req_ready[0] === 1'b1 && first_rdy0 < 0) first_rdy0 = cyc;
  end

  task automatic clear_logs();
    wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete(); glog.delete();
    first_rdy0 = -1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_sources();
    repeat (3) step();
    rstn = 1'b1;
    clear_logs();
  endtask

  task automatic wait_writes(input string name, input int n, input int max_cyc);
    int c = 0;
    while (wlog_addr.size() < n && c < max_cyc) begin
      step();
      c++;
    end
    if (wlog_addr.size() < n) chk({name, "_timeout"}, 32'(wlog_addr.size()), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n_before;
    clear_sources();

    // Reset state
    do_reset();
    step();
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Single 4-beat burst from requester 0
    c0 = cyc;
    src(0, 4, 4, 0, 'h100);
    apply();
    wait_writes("t1", 4, 20);
    repeat (3) step();
    chk("t1_first_ready", 32'(first_rdy0 - c0), 32'd1);
    chk("t1_nwrites", 32'(wlog_addr.size()), 32'd4);
    chk("t1_first_wr_cyc", 32'(wlog_cyc[0] - c0), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 32'(wlog_addr[i]), 32'(i));
      chk("t1_cyc", 32'(wlog_cyc[i] - wlog_cyc[0]), 32'(i));
    end
    chk("t1_data3", 32'(wlog_data[3]), 32'h103);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // All three requesters, 2-beat bursts
    do_reset();
    for (int i = 0; i < NR; i++) src(i, 2, 4, i * 100, i * 16);
    apply();
    wait_writes("t2", 12, 100);
    repeat (3) step();
    chk("t2_nbursts", 32'(glog.size()), 32'd6);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("t2_grant_order", 32'(glog[i]), 32'(i % 3));
    for (int b = 0; b < 6; b++) begin
      chk("t2_intra_gap", 32'(wlog_cyc[2*b+1] - wlog_cyc[2*b]), 32'd1);
      if (b < 5) chk("t2_dead_cycle", 32'(wlog_cyc[2*b+2] - wlog_cyc[2*b+1]), 32'd2);
    end
    chk("t2_addr2", 32'(wlog_addr[2]), 32'd100);
    chk("t2_addr5", 32'(wlog_addr[5]), 32'd201);

    // Requester 1 streams 100 beats with no last
    do_reset();
    src(1, 0, 100, 0, 0);
    apply();
    wait_writes("t3", 100, 400);
    repeat (3) step();
    chk("t3_nwrites", 32'(wlog_addr.size()), 32'd100);
    chk("t3_nbursts", 32'(glog.size()), 32'd2);
    chk("t3_grant0", 32'(glog[0]), 32'd1);
    chk("t3_grant1", 32'(glog[1]), 32'd1);
    chk("t3_release_gap", 32'(wlog_cyc[64] - wlog_cyc[63]), 32'd2);
    chk("t3_pre_gap", 32'(wlog_cyc[63] - wlog_cyc[62]), 32'd1);
    chk("t3_addr64", 32'(wlog_addr[64]), 32'd64);
    chk("t3_addr99", 32'(wlog_addr[99]), 32'd99);

    // Owner stalls 5 cycles while requester 2 waits
    do_reset();
    src(0, 8, 8, 0, 0);
    src(2, 2, 2, 500, 0);
    apply();
    wait_writes("t4a", 3, 20);
    s_hold[0] = 1'b1;
    apply();
    n_before = wlog_addr.size();
    repeat (5) begin
      step();
      chk("t4_gap_grant", 32'(grant_id), 32'd0);
      chk("t4_gap_busy", 32'(busy), 32'd1);
    end
    chk("t4_gap_nowrite", 32'(wlog_addr.size()), 32'(n_before));
    s_hold[0] = 1'b0;
    apply();
    wait_writes("t4b", 10, 40);
    repeat (3) step();
    chk("t4_nbursts", 32'(glog.size()), 32'd2);
    chk("t4_grant0", 32'(glog[0]), 32'd0);
    chk("t4_grant1", 32'(glog[1]), 32'd2);
    chk("t4_resume_addr", 32'(wlog_addr[3]), 32'd3);
    chk("t4_req2_addr", 32'(wlog_addr[8]), 32'd500);

    // Reset during beat 3 of a burst
    do_reset();
    src(0, 8, 8, 0, 0);
    src(1, 2, 2, 40, 0);
    apply();
    wait_writes("t5a", 3, 20);
    chk("t5_pre_we", 32'(write_en), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_rst_we", 32'(write_en), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    clear_sources();
    repeat (2) step();
    rstn = 1'b1;
    clear_logs();
    step();
    chk("t5_post_we", 32'(write_en), 32'd0);
    src(0, 2, 2, 0, 0);
    src(1, 2, 2, 40, 0);
    apply();
    wait_writes("t5b", 4, 30);
    chk("t5_first_grant", 32'(glog[0]), 32'd0);
    chk("t5_second_grant", 32'(glog[1]), 32'd1);

`ifdef FB_ARB_BOUNDS_CHECK_EN
    // Out-of-range beat is accepted but not written
    do_reset();
    src(0, 2, 2, FB_SIZE - 1, 'h55);
    apply();
    wait_writes("t6", 1, 20);
    repeat (4) step();
    chk("t6_nwrites", 32'(wlog_addr.size()), 32'd1);
    chk("t6_last_addr", 32'(write_addr), 32'(FB_SIZE - 1));
    chk("t6_handshake", 32'(s_left[0]), 32'd0);
    chk("t6_err", 32'(addr_error), 32'd1);
    repeat (5) step();
    chk("t6_err_hold", 32'(addr_error), 32'd1);
    do_reset();
    chk("t6_err_clr", 32'(addr_error), 32'd0);
`endif

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of framebuffer write requesters (index 0 = background, 1 = sprites, 2 = overlay).
REQ-002 Parameter BUFFER_WIDTH, default 160: framebuffer width in pixels.
REQ-003 Parameter BUFFER_HEIGHT, default 120: framebuffer height in pixels.
REQ-004 Parameter BUFFER_DATA_WIDTH, default 12: pixel width in bits.
REQ-005 Parameter BUFFER_ADDR_WIDTH, default $clog2(BUFFER_WIDTH*BUFFER_HEIGHT): address width.
REQ-006 Parameter MAX_BURST, default 64: beats before a grant is forcibly released; 0 means unlimited.
REQ-007 Ports, with name, direction, width and meaning, SHALL be:
- clk  in  1  sole clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester final beat of burst.
- req_addr  in  NUM_REQ*BUFFER_ADDR_WIDTH  packed per-requester address.
- req_data  in  NUM_REQ*BUFFER_DATA_WIDTH  packed per-requester pixel.
- req_ready  out  NUM_REQ  per-requester beat accepted.
- write_en  out  1  framebuffer write strobe.
- write_addr  out  BUFFER_ADDR_WIDTH  framebuffer address.
- write_data  out  BUFFER_DATA_WIDTH  framebuffer pixel.
- grant_id  out  $clog2(NUM_REQ)  current or last owner.
- busy  out  1  a burst is in progress.

Function
REQ-008 State machine SHALL have exactly two states: ARB and BURST.
REQ-009 In ARB, when any req_valid is high, the arbiter SHALL pick the first requester with valid high, searching round-robin from (last_grant+1) mod NUM_REQ, register grant_id, and enter BURST on the next edge.
REQ-010 In ARB, all req_ready bits SHALL be 0; no beat is accepted in ARB.
REQ-011 In BURST, req_ready SHALL be 1 only for grant_id; all other bits SHALL be 0.
REQ-012 A beat transfers when req_valid[g] && req_ready[g]; write_en, write_addr and write_data SHALL reflect that beat exactly one cycle later, registered.
REQ-013 write_en SHALL be 0 in every cycle not following a transfer; write_addr and write_data SHALL hold their previous values when write_en is 0.
REQ-014 A transfer with req_last[g]=1 SHALL return the machine to ARB and set last_grant to g; ARB costs exactly one dead cycle between bursts.
REQ-015 With MAX_BURST>0, the beat counter SHALL reset at BURST entry; the MAX_BURST-th transfer SHALL force return to ARB even if req_last=0.
REQ-016 The owner's remaining beats after a forced release SHALL rejoin arbitration normally.
REQ-017 req_valid low in BURST SHALL stall the burst without releasing the grant.
REQ-018 req_addr, req_data and req_last of non-granted requesters SHALL be ignored.
REQ-019 busy SHALL be 1 exactly while in BURST.

Reset
REQ-020 On rstn low, asynchronously: state=ARB, last_grant=NUM_REQ-1 (so requester 0 wins first), grant_id=0, beat counter=0, write_en=0, write_addr=0, write_data=0, busy=0, req_ready=0.
REQ-021 Reset mid-burst SHALL abandon the burst; no write_en pulse SHALL follow reset release until a new transfer occurs.

Configuration
REQ-022 Macro FB_ARB_BOUNDS_CHECK_EN: when defined, a transfer with address >= BUFFER_WIDTH*BUFFER_HEIGHT SHALL be accepted (ready handshake unchanged) but SHALL NOT produce write_en, and a sticky output addr_error (1 bit, reset 0) SHALL be set.
REQ-023 Without FB_ARB_BOUNDS_CHECK_EN, addresses SHALL pass through unchecked and the addr_error port SHALL NOT exist.

Structure
REQ-024 Package fb_pkg SHALL hold the arb_state_t enum, the default BUFFER_WIDTH, BUFFER_HEIGHT and BUFFER_DATA_WIDTH constants, and the requester index constants REQ_BG, REQ_SPRITE and REQ_OVERLAY.
REQ-025 Sub-module rr_picker (combinational: request vector + last_grant -> next grant + any_req) SHALL implement the round-robin search; the FSM, counter and output registers SHALL stay in fb_write_arbiter.

Verification
REQ-026 Reset, then req_valid[0] for a 4-beat burst, addr 0..3, last on beat 4 -> ready[0] high from cycle 2, write_en for 4 consecutive cycles at addr 0..3, then busy=0.
REQ-027 All three valid continuously, 2-beat bursts -> grant order 0,1,2,0,1,2 with exactly one dead cycle between bursts.
REQ-028 MAX_BURST=64, requester 1 streams 100 beats with no last -> forced release after beat 64; with only requester 1 valid it is re-granted, 36 more beats follow, total 100 writes.
REQ-029 Granted requester drops valid for 5 cycles mid-burst while requester 2 is valid -> grant_id unchanged, no write_en during the gap, burst resumes.
REQ-030 Assert rstn low during beat 3 of a burst -> write_en=0 immediately and stays 0; after release, requester 0 wins the first arbitration.
REQ-031 With FB_ARB_BOUNDS_CHECK_EN defined, a beat at addr 19200 -> req_ready handshake completes, write_en stays 0, addr_error=1 and holds until reset.
